// File: rtl/pixel_coord_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mandel_pkg
// Shared types for the pixel coordinate sequencer and its neighbours.
//   seq_state_t : sequencer FSM states
//   rgb_t       : 24-bit {R,G,B} colour word
//   COORD_W     : width of the x/y pixel counters
// ---------------------------------------------------------------------------
package mandel_pkg;

    localparam int COORD_W = 11;

    typedef logic [23:0] rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        EMIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/pixel_coord_sequencer_if.sv
// ---------------------------------------------------------------------------
// pixel_coord_sequencer_if
// Bundles the two handshakes of the sequencer:
//   dc_*  : start/done handshake with the depth/colour stage (plus c and colour)
//   pix_* : valid/ready pixel stream towards the video output
// Modports:
//   master : the sequencer (drives dc_start, re_c, im_c and the pixel stream)
//   slave  : the depth stage / pixel sink side
// ---------------------------------------------------------------------------
interface pixel_coord_sequencer_if #(
    parameter int WL = 64
);
    import mandel_pkg::*;

    logic          dc_start;
    logic [WL-1:0] re_c;
    logic [WL-1:0] im_c;
    logic          dc_done;
    rgb_t          dc_color;

    rgb_t          pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;

    modport master (
        output dc_start, re_c, im_c, pix_data, pix_valid, pix_sof, pix_eol,
        input  dc_done, dc_color, pix_ready
    );

    modport slave (
        input  dc_start, re_c, im_c, pix_data, pix_valid, pix_sof, pix_eol,
        output dc_done, dc_color, pix_ready
    );

endinterface

// File: rtl/pixel_coord_sequencer_coord_stepper.sv
// ---------------------------------------------------------------------------
// coord_stepper
// Incremental complex-plane coordinate generator (no multipliers).
// Holds the current real/imaginary accumulators, the real value of the start
// of the row, and the per-pixel step. All arithmetic wraps.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_load              : load re_min/im_max/step (start of frame)
//   i_step_x            : move one pixel right (re += step)
//   i_step_y            : move to start of next line (re = row start, im -= step)
//   i_re_min, i_im_max, i_step : frame parameters, sampled on i_load
//   o_re_next, o_im_next: value the accumulators take at the next edge, so the
//                         caller can register c in the same cycle it steps
// ---------------------------------------------------------------------------
module coord_stepper #(
    parameter int WL = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step_x,
    input  logic          i_step_y,
    input  logic [WL-1:0] i_re_min,
    input  logic [WL-1:0] i_im_max,
    input  logic [WL-1:0] i_step,
    output logic [WL-1:0] o_re_next,
    output logic [WL-1:0] o_im_next
);

    logic [WL-1:0] r_re_acc;
    logic [WL-1:0] r_row_re;
    logic [WL-1:0] r_im_acc;
    logic [WL-1:0] r_step;

    logic [WL-1:0] w_re_next;
    logic [WL-1:0] w_row_next;
    logic [WL-1:0] w_im_next;
    logic [WL-1:0] w_step_next;

    // Next-state selection: load wins over stepping; a line change returns
    // the real part to the row start rather than subtracting the line width.
    always_comb begin
        w_re_next   = r_re_acc;
        w_row_next  = r_row_re;
        w_im_next   = r_im_acc;
        w_step_next = r_step;
        if (i_load) begin
            w_re_next   = i_re_min;
            w_row_next  = i_re_min;
            w_im_next   = i_im_max;
            w_step_next = i_step;
        end else if (i_step_x) begin
            w_re_next = r_re_acc + r_step;
        end else if (i_step_y) begin
            w_re_next = r_row_re;
            w_im_next = r_im_acc - r_step;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_acc <= '0;
            r_row_re <= '0;
            r_im_acc <= '0;
            r_step   <= '0;
        end else begin
            r_re_acc <= w_re_next;
            r_row_re <= w_row_next;
            r_im_acc <= w_im_next;
            r_step   <= w_step_next;
        end
    end

    assign o_re_next = w_re_next;
    assign o_im_next = w_im_next;

endmodule

// File: rtl/pixel_coord_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_coord_sequencer
// Raster-scans one frame (x fastest), issues c = re_c + j*im_c for every pixel
// to the depth/colour stage, waits for it, captures the colour and emits it on
// a valid/ready pixel stream with start-of-frame / end-of-line flags.
// Ports:
//   sysclk, reset_n        : clock, asynchronous active-low reset
//   frame_start            : begin a frame (only honoured in IDLE)
//   re_min, im_max, step   : frame coordinates, sampled on accepted frame_start
//   bus (master)           : dc_* depth-stage handshake and pix_* stream
//   x_out, y_out           : current pixel position
//   busy                   : sequencer is not IDLE
//   frame_done             : one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module pixel_coord_sequencer
    import mandel_pkg::*;
#(
    parameter int FRAC        = 60,
    parameter int WORD_LENGTH = 64,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int COLOR_LAT   = 1
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_min,
    input  logic [WORD_LENGTH-1:0] im_max,
    input  logic [WORD_LENGTH-1:0] step,
    pixel_coord_sequencer_if.master bus,
    output logic [COORD_W-1:0]     x_out,
    output logic [COORD_W-1:0]     y_out,
    output logic                   busy,
    output logic                   frame_done
);

    // The fixed-point format only needs an integer part to exist.
    if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_bad_frac
        $error("FRAC must lie in 0..WORD_LENGTH-1");
    end

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_RES - 1);
    // A latency of 0 is treated as 1: the colour is always taken in CAPTURE.
    localparam logic [7:0]         LAT_LAST = 8'((COLOR_LAT > 1) ? COLOR_LAT - 1 : 0);

    seq_state_t             r_state;
    logic                   r_done_prev;
    logic [7:0]             r_lat_cnt;
    logic [COORD_W-1:0]     r_x;
    logic [COORD_W-1:0]     r_y;
    logic                   r_busy;
    logic                   r_frame_done;

    logic                   w_load;
    logic                   w_handshake;
    logic                   w_last_pix;
    logic                   w_step_x;
    logic                   w_step_y;
    logic [WORD_LENGTH-1:0] w_re_next;
    logic [WORD_LENGTH-1:0] w_im_next;

    // Control decode for the coordinate stepper. The last pixel of the frame
    // does not step, so the accumulators simply hold until the next load.
    always_comb begin
        w_load      = (r_state == IDLE) && frame_start;
        w_handshake = (r_state == EMIT) && bus.pix_ready;
        w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
        w_step_x    = w_handshake && !w_last_pix && (r_x != X_LAST);
        w_step_y    = w_handshake && !w_last_pix && (r_x == X_LAST);
    end

    coord_stepper #(
        .WL (WORD_LENGTH)
    ) u_stepper (
        .clk       (sysclk),
        .rst_n     (reset_n),
        .i_load    (w_load),
        .i_step_x  (w_step_x),
        .i_step_y  (w_step_y),
        .i_re_min  (re_min),
        .i_im_max  (im_max),
        .i_step    (step),
        .o_re_next (w_re_next),
        .o_im_next (w_im_next)
    );

    // Sequencer FSM with all outputs registered. re_c/im_c are taken from the
    // stepper's next value on entry to ISSUE so they are already valid while
    // dc_start is high, and held until the following handshake. dc_done is
    // edge-detected so a level-style done is counted once.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_done_prev   <= 1'b0;
            r_lat_cnt     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            bus.dc_start  <= 1'b0;
            bus.re_c      <= '0;
            bus.im_c      <= '0;
            bus.pix_data  <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
        end else begin
            r_done_prev <= bus.dc_done;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_x          <= '0;
                        r_y          <= '0;
                        r_busy       <= 1'b1;
                        bus.dc_start <= 1'b1;
                        bus.re_c     <= w_re_next;
                        bus.im_c     <= w_im_next;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.dc_start <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (bus.dc_done && !r_done_prev) begin
                        r_lat_cnt <= '0;
                        r_state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        bus.pix_data  <= bus.dc_color;
                        bus.pix_valid <= 1'b1;
                        bus.pix_sof   <= (r_x == '0) && (r_y == '0);
                        bus.pix_eol   <= (r_x == X_LAST);
                        r_state       <= EMIT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                    end
                end
                EMIT: begin
                    if (bus.pix_ready) begin
                        bus.pix_valid <= 1'b0;
                        bus.pix_sof   <= 1'b0;
                        bus.pix_eol   <= 1'b0;
                        if (w_last_pix) begin
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                            bus.dc_start <= 1'b1;
                            bus.re_c     <= w_re_next;
                            bus.im_c     <= w_im_next;
                            r_state      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_coord_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_coord_sequencer
// Drives a 4x2 sequencer and a 1x1 sequencer, each paired with a small
// behavioural depth stage, and checks the pixel stream against a table of
// hand-computed per-pixel expectations (Q4.60 coordinates).
// ---------------------------------------------------------------------------
module tb_pixel_coord_sequencer;

    localparam logic [63:0] RM2  = 64'hE000_0000_0000_0000; // -2.0
    localparam logic [63:0] RM15 = 64'hE800_0000_0000_0000; // -1.5
    localparam logic [63:0] RM1  = 64'hF000_0000_0000_0000; // -1.0
    localparam logic [63:0] RM05 = 64'hF800_0000_0000_0000; // -0.5
    localparam logic [63:0] IP1  = 64'h1000_0000_0000_0000; //  1.0
    localparam logic [63:0] IP05 = 64'h0800_0000_0000_0000; //  0.5

    typedef struct {
        logic        readyEarly;
        int          holdCycles;
        logic        pulseStart;
        logic [10:0] x;
        logic [10:0] y;
        logic [63:0] re;
        logic [63:0] im;
        logic        sof;
        logic        eol;
        logic [23:0] color;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    logic        sysclk = 1'b0;
    logic        reset_n;

    logic        frameStartA;
    logic [63:0] reMinA, imMaxA, stepA;
    logic [10:0] xA, yA;
    logic        busyA, frameDoneA;

    logic        frameStartB;
    logic [63:0] reMinB, imMaxB, stepB;
    logic [10:0] xB, yB;
    logic        busyB, frameDoneB;

    pixel_coord_sequencer_if #(.WL(64)) busA ();
    pixel_coord_sequencer_if #(.WL(64)) busB ();

    pixel_coord_sequencer #(
        .FRAC(60), .WORD_LENGTH(64), .H_RES(4), .V_RES(2), .COLOR_LAT(1)
    ) dutA (
        .sysclk(sysclk), .reset_n(reset_n), .frame_start(frameStartA),
        .re_min(reMinA), .im_max(imMaxA), .step(stepA), .bus(busA.master),
        .x_out(xA), .y_out(yA), .busy(busyA), .frame_done(frameDoneA)
    );

    pixel_coord_sequencer #(
        .FRAC(60), .WORD_LENGTH(64), .H_RES(1), .V_RES(1), .COLOR_LAT(1)
    ) dutB (
        .sysclk(sysclk), .reset_n(reset_n), .frame_start(frameStartB),
        .re_min(reMinB), .im_max(imMaxB), .step(stepB), .bus(busB.master),
        .x_out(xB), .y_out(yB), .busy(busyB), .frame_done(frameDoneB)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Depth stage model for A: done 5 cycles after start, colour one cycle later.
    int          issueA = 0;
    int          cdA = 0;
    bit          pendA = 0;
    int          pendIdxA = 0;
    logic [63:0] issRe[16];
    logic [63:0] issIm[16];
    int          frameDoneCntA = 0;

    initial begin
        busA.dc_done  = 1'b0;
        busA.dc_color = '0;
        forever begin
            @(negedge sysclk);
            if (frameDoneA) frameDoneCntA++;
            busA.dc_done  = 1'b0;
            busA.dc_color = '0;
            if (!reset_n) begin
                cdA   = 0;
                pendA = 0;
                continue;
            end
            if (pendA) begin
                busA.dc_color = vecs[pendIdxA % 8].color;
                pendA = 0;
            end
            if (cdA > 0) begin
                cdA--;
                if (cdA == 0) begin
                    busA.dc_done = 1'b1;
                    pendA = 1;
                    pendIdxA = issueA - 1;
                    checkOutput("re_c held until done", busA.re_c, issRe[(issueA - 1) % 16]);
                end
            end
            if (busA.dc_start) begin
                issRe[issueA % 16] = busA.re_c;
                issIm[issueA % 16] = busA.im_c;
                issueA++;
                cdA = 5;
            end
        end
    end

    // Depth stage model for B: done 3 cycles after start, fixed green colour.
    int          issueB = 0;
    int          cdB = 0;
    bit          pendB = 0;
    logic [63:0] issReB = '0;
    int          frameDoneCntB = 0;

    initial begin
        busB.dc_done  = 1'b0;
        busB.dc_color = '0;
        forever begin
            @(negedge sysclk);
            if (frameDoneB) frameDoneCntB++;
            busB.dc_done  = 1'b0;
            busB.dc_color = '0;
            if (!reset_n) begin
                cdB   = 0;
                pendB = 0;
                continue;
            end
            if (pendB) begin
                busB.dc_color = 24'h00FF00;
                pendB = 0;
            end
            if (cdB > 0) begin
                cdB--;
                if (cdB == 0) begin
                    busB.dc_done = 1'b1;
                    pendB = 1;
                end
            end
            if (busB.dc_start) begin
                issReB = busB.re_c;
                issueB++;
                cdB = 3;
            end
        end
    end

    task automatic waitValidA(output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (busA.pix_valid) begin
                ok = 1;
                break;
            end
            @(negedge sysclk);
        end
    endtask

    // Starts a frame on A and walks the vector table, one pixel per entry.
    task automatic applyStimulus();
        bit ok;
        bit bad;
        issueA = 0;
        reMinA = RM2;
        imMaxA = IP1;
        stepA  = IP05;
        checkOutput("idle busy", busyA, 0);
        @(negedge sysclk);
        frameStartA = 1'b1;
        @(negedge sysclk);
        frameStartA = 1'b0;
        checkOutput("busy after start", busyA, 1);
        for (int i = 0; i < 8; i++) begin
            busA.pix_ready = vecs[i].readyEarly;
            if (vecs[i].pulseStart) begin
                frameStartA = 1'b1;
                reMinA = '0;
                @(negedge sysclk);
                frameStartA = 1'b0;
            end
            waitValidA(ok);
            if (!ok) begin
                checkOutput("pix_valid timeout", 0, 1);
                return;
            end
            checkOutput($sformatf("pix%0d data", i), busA.pix_data, vecs[i].color);
            checkOutput($sformatf("pix%0d sof", i), busA.pix_sof, vecs[i].sof);
            checkOutput($sformatf("pix%0d eol", i), busA.pix_eol, vecs[i].eol);
            checkOutput($sformatf("pix%0d x", i), xA, vecs[i].x);
            checkOutput($sformatf("pix%0d y", i), yA, vecs[i].y);
            checkOutput($sformatf("pix%0d re_c", i), issRe[i], vecs[i].re);
            checkOutput($sformatf("pix%0d im_c", i), issIm[i], vecs[i].im);
            checkOutput($sformatf("pix%0d issue count", i), issueA, i + 1);
            if (!vecs[i].readyEarly) begin
                bad = 0;
                repeat (vecs[i].holdCycles) begin
                    @(negedge sysclk);
                    if (busA.pix_valid !== 1'b1 || busA.pix_data !== vecs[i].color ||
                        busA.pix_sof !== vecs[i].sof || busA.pix_eol !== vecs[i].eol ||
                        busA.dc_start !== 1'b0)
                        bad = 1;
                end
                checkOutput($sformatf("pix%0d backpressure hold", i), bad, 0);
                busA.pix_ready = 1'b1;
            end
            @(negedge sysclk);
            busA.pix_ready = 1'b0;
            checkOutput($sformatf("pix%0d valid drop", i), busA.pix_valid, 0);
            checkOutput($sformatf("pix%0d frame_done", i), frameDoneA, (i == 7));
        end
        @(negedge sysclk);
        checkOutput("frame_done one cycle", frameDoneA, 0);
        checkOutput("busy after frame", busyA, 0);
        checkOutput("issues per frame", issueA, 8);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        //           early hold pulse x      y      re    im    sof   eol   colour
        vecs[0] = '{1'b1, 0,  1'b0, 11'd0, 11'd0, RM2,  IP1,  1'b1, 1'b0, 24'hFF0000};
        vecs[1] = '{1'b1, 0,  1'b0, 11'd1, 11'd0, RM15, IP1,  1'b0, 1'b0, 24'h00FF00};
        vecs[2] = '{1'b0, 10, 1'b0, 11'd2, 11'd0, RM1,  IP1,  1'b0, 1'b0, 24'h0000FF};
        vecs[3] = '{1'b1, 0,  1'b0, 11'd3, 11'd0, RM05, IP1,  1'b0, 1'b1, 24'h123456};
        vecs[4] = '{1'b1, 0,  1'b1, 11'd0, 11'd1, RM2,  IP05, 1'b0, 1'b0, 24'hABCDEF};
        vecs[5] = '{1'b1, 0,  1'b0, 11'd1, 11'd1, RM15, IP05, 1'b0, 1'b0, 24'h0F0F0F};
        vecs[6] = '{1'b1, 0,  1'b0, 11'd2, 11'd1, RM1,  IP05, 1'b0, 1'b0, 24'hF0F0F0};
        vecs[7] = '{1'b1, 0,  1'b0, 11'd3, 11'd1, RM05, IP05, 1'b0, 1'b1, 24'h808080};

        reset_n = 1'b0;
        frameStartA = 1'b0; reMinA = '0; imMaxA = '0; stepA = '0;
        frameStartB = 1'b0; reMinB = '0; imMaxB = '0; stepB = '0;
        busA.pix_ready = 1'b0;
        busB.pix_ready = 1'b0;
        repeat (3) @(negedge sysclk);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset dc_start", busA.dc_start, 0);
        checkOutput("reset pix_valid", busA.pix_valid, 0);
        checkOutput("reset re_c", busA.re_c, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge sysclk);

        $display("[TB] 4x2 frame with backpressure and ignored mid-frame start");
        applyStimulus();
        checkOutput("frame_done pulses after frame 1", frameDoneCntA, 1);

        $display("[TB] reset while waiting on pixel 3");
        issueA = 0;
        reMinA = RM2; imMaxA = IP1; stepA = IP05;
        busA.pix_ready = 1'b1;
        frameStartA = 1'b1;
        @(negedge sysclk);
        frameStartA = 1'b0;
        for (int k = 0; k < 300 && issueA < 4; k++) @(negedge sysclk);
        checkOutput("reached pixel 3", issueA, 4);
        repeat (2) @(negedge sysclk);
        checkOutput("pre-reset x", xA, 3);
        checkOutput("pre-reset busy", busyA, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset busy", busyA, 0);
        checkOutput("async reset x", xA, 0);
        checkOutput("async reset re_c", busA.re_c, 0);
        checkOutput("async reset im_c", busA.im_c, 0);
        checkOutput("async reset pix_data", busA.pix_data, 0);
        checkOutput("async reset pix_valid", busA.pix_valid, 0);
        checkOutput("async reset dc_start", busA.dc_start, 0);
        busA.pix_ready = 1'b0;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        repeat (20) @(negedge sysclk);
        checkOutput("no frame_done after abort", frameDoneCntA, 1);
        checkOutput("idle after abort", busyA, 0);
        checkOutput("no partial pixel", busA.pix_valid, 0);

        $display("[TB] restart after reset");
        applyStimulus();
        checkOutput("frame_done pulses after restart", frameDoneCntA, 2);

        $display("[TB] 1x1 frame");
        reMinB = RM15; imMaxB = IP05; stepB = IP05;
        busB.pix_ready = 1'b0;
        frameStartB = 1'b1;
        @(negedge sysclk);
        frameStartB = 1'b0;
        for (int k = 0; k < 200 && !busB.pix_valid; k++) @(negedge sysclk);
        checkOutput("1x1 valid", busB.pix_valid, 1);
        checkOutput("1x1 data", busB.pix_data, 24'h00FF00);
        checkOutput("1x1 sof", busB.pix_sof, 1);
        checkOutput("1x1 eol", busB.pix_eol, 1);
        checkOutput("1x1 re_c", issReB, RM15);
        busB.pix_ready = 1'b1;
        @(negedge sysclk);
        busB.pix_ready = 1'b0;
        checkOutput("1x1 frame_done", frameDoneB, 1);
        checkOutput("1x1 valid drop", busB.pix_valid, 0);
        @(negedge sysclk);
        checkOutput("1x1 frame_done pulse", frameDoneB, 0);
        checkOutput("1x1 idle", busyB, 0);
        repeat (10) @(negedge sysclk);
        checkOutput("1x1 single issue", issueB, 1);
        checkOutput("1x1 single frame_done", frameDoneCntB, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
